// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one four-banked main memory between the instruction-cache
//   controller (I side) and the data-cache controller (D side). A requester
//   holds its req for a whole transaction and keeps the grant until req
//   drops. Before the memory is handed over, in-flight bank accesses are
//   drained (mem_busy != 0). Address, data and strobes of the owner are
//   routed to memory. The non-owner is stalled. Read data is broadcast.
//
//   State | Meaning
//   ------+------------------------------------------------------------
//   IDLE  | no owner; arbitrate pending requests (always one cycle)
//   OWN_I | I side owns the memory until i_req drops
//   OWN_D | D side owns the memory until d_req drops
//   DRAIN | former owner released; wait for mem_busy to clear
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   i_req/i_rd/i_wr          I side transaction request and strobes
//   i_addr/i_wdata           I side address and write data
//   d_req/d_rd/d_wr          D side transaction request and strobes
//   d_addr/d_wdata           D side address and write data
//   mem_busy, mem_stall      per-bank busy and stall from memory
//   mem_rdata                read data from memory
//   mem_rd/mem_wr            strobes to memory (owner only)
//   mem_addr/mem_wdata       owner's address/data, zero with no owner
//   i_gnt/d_gnt              registered ownership flags
//   i_stall/d_stall          stall back to each requester
//   rdata                    mem_rdata broadcast to both sides
//   hold_err                 sticky: owner held too long while other waited

module mem_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int PRIO_MODE = 0,
    parameter int MAX_HOLD  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic              i_rd,
    input  logic              i_wr,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              d_req,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        mem_busy,
    input  logic              mem_stall,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              i_gnt,
    output logic              d_gnt,
    output logic              i_stall,
    output logic              d_stall,
    output logic [DATA_W-1:0] rdata,
    output logic              hold_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_I = 2'd1,
        OWN_D = 2'd2,
        DRAIN = 2'd3
    } state_e;

    localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);
    localparam logic       FIXED_PRIO = (PRIO_MODE != 0);

    state_e     state_q, state_d;
    logic       last_d_q;       // 1: last owner was D, 0: last owner was I
    logic       i_gnt_q, d_gnt_q;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic       hold_err_q;
    logic       busy_any;

    assign busy_any = |mem_busy;

    // Next-state arbitration
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (i_req && d_req) begin
                    // Tie: fixed mode always favours D; round-robin favours
                    // the side that did not own the memory last.
                    state_d = (FIXED_PRIO || !last_d_q) ? OWN_D : OWN_I;
                end else if (d_req) begin
                    state_d = OWN_D;
                end else if (i_req) begin
                    state_d = OWN_I;
                end
            end
            OWN_I: begin
                if (!i_req) state_d = busy_any ? DRAIN : IDLE;
            end
            OWN_D: begin
                if (!d_req) state_d = busy_any ? DRAIN : IDLE;
            end
            DRAIN: begin
                if (!busy_any) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Hold counter: counts owner cycles during which the other side waits.
    // It holds its value on owner cycles with no waiter and clears outside
    // ownership. Saturates at 8'hFF.
    always_comb begin
        hold_cnt_d = 8'd0;
        if (state_q == OWN_I) begin
            hold_cnt_d = (d_req && hold_cnt_q != 8'hFF) ? hold_cnt_q + 8'd1 : hold_cnt_q;
        end else if (state_q == OWN_D) begin
            hold_cnt_d = (i_req && hold_cnt_q != 8'hFF) ? hold_cnt_q + 8'd1 : hold_cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_d_q   <= 1'b0;
            i_gnt_q    <= 1'b0;
            d_gnt_q    <= 1'b0;
            hold_cnt_q <= 8'd0;
            hold_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            i_gnt_q    <= (state_d == OWN_I);
            d_gnt_q    <= (state_d == OWN_D);
            hold_cnt_q <= hold_cnt_d;
            if (state_q == IDLE && state_d == OWN_I) last_d_q <= 1'b0;
            if (state_q == IDLE && state_d == OWN_D) last_d_q <= 1'b1;
            // Every value is passed on the way up, so an equality test
            // is enough; the flag is sticky until reset.
            if (hold_cnt_d == MAX_HOLD_C) hold_err_q <= 1'b1;
        end
    end

    // Owner routing; strobes from a non-owner never reach memory.
    always_comb begin
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (i_gnt_q) begin
            mem_rd    = i_rd;
            mem_wr    = i_wr;
            mem_addr  = i_addr;
            mem_wdata = i_wdata;
        end else if (d_gnt_q) begin
            mem_rd    = d_rd;
            mem_wr    = d_wr;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end
    end

    assign i_gnt    = i_gnt_q;
    assign d_gnt    = d_gnt_q;
    assign i_stall  = ~i_gnt_q | mem_stall;
    assign d_stall  = ~d_gnt_q | mem_stall;
    assign rdata    = mem_rdata;
    assign hold_err = hold_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req, i_rd, i_wr, d_req, d_rd, d_wr;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] i_wdata, d_wdata, mem_rdata;
    logic [3:0]    mem_busy;
    logic          mem_stall;

    logic [1:0]         mem_rd_w, mem_wr_w, i_gnt_w, d_gnt_w;
    logic [1:0]         i_stall_w, d_stall_w, hold_err_w;
    logic [1:0][AW-1:0] mem_addr_w;
    logic [1:0][DW-1:0] mem_wdata_w, rdata_w;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Instance 0: round-robin, hold limit 4. Instance 1: fixed D priority, limit 8.
    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(0), .MAX_HOLD(4)) u_rr (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_rd(i_rd), .i_wr(i_wr), .i_addr(i_addr), .i_wdata(i_wdata),
        .d_req(d_req), .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .mem_busy(mem_busy), .mem_stall(mem_stall), .mem_rdata(mem_rdata),
        .mem_rd(mem_rd_w[0]), .mem_wr(mem_wr_w[0]), .mem_addr(mem_addr_w[0]),
        .mem_wdata(mem_wdata_w[0]), .i_gnt(i_gnt_w[0]), .d_gnt(d_gnt_w[0]),
        .i_stall(i_stall_w[0]), .d_stall(d_stall_w[0]), .rdata(rdata_w[0]),
        .hold_err(hold_err_w[0])
    );

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(1), .MAX_HOLD(8)) u_fp (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_rd(i_rd), .i_wr(i_wr), .i_addr(i_addr), .i_wdata(i_wdata),
        .d_req(d_req), .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .mem_busy(mem_busy), .mem_stall(mem_stall), .mem_rdata(mem_rdata),
        .mem_rd(mem_rd_w[1]), .mem_wr(mem_wr_w[1]), .mem_addr(mem_addr_w[1]),
        .mem_wdata(mem_wdata_w[1]), .i_gnt(i_gnt_w[1]), .d_gnt(d_gnt_w[1]),
        .i_stall(i_stall_w[1]), .d_stall(d_stall_w[1]), .rdata(rdata_w[1]),
        .hold_err(hold_err_w[1])
    );

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d] at %0t: got %h expected %h", nm, k, $time, act, exp);
        end
    endtask

    // Reference model: who owns the memory (0 none, 1 I, 2 D), whether a
    // release is waiting on busy banks, who owned last, wait counter, error.
    int m_own[2], m_last[2], m_cnt[2];
    bit m_drn[2], m_err[2];
    bit m_valid = 0;
    int PRIO[2] = '{0, 1};
    int MH[2]   = '{4, 8};

    initial begin
        int  w;
        bit  mine, other;
        forever begin
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                if (rst) begin
                    m_own[k] = 0; m_drn[k] = 0; m_last[k] = 1; m_cnt[k] = 0; m_err[k] = 0;
                end else if (m_own[k] != 0) begin
                    mine  = (m_own[k] == 1) ? i_req : d_req;
                    other = (m_own[k] == 1) ? d_req : i_req;
                    if (other && m_cnt[k] < 255) m_cnt[k]++;
                    if (m_cnt[k] == MH[k]) m_err[k] = 1;
                    if (!mine) begin
                        m_drn[k] = (mem_busy != 0);
                        m_own[k] = 0;
                    end
                end else begin
                    m_cnt[k] = 0;
                    if (m_drn[k]) begin
                        if (mem_busy == 0) m_drn[k] = 0;
                    end else begin
                        if (i_req && d_req) w = (PRIO[k] == 1 || m_last[k] == 1) ? 2 : 1;
                        else if (d_req)     w = 2;
                        else if (i_req)     w = 1;
                        else                w = 0;
                        if (w != 0) begin
                            m_own[k]  = w;
                            m_last[k] = w;
                        end
                    end
                end
            end
            if (rst) m_valid = 1;
        end
    end

    // Compare process: every negedge, both instances against the model.
    initial begin
        bit eig, edg;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                for (int k = 0; k < 2; k++) begin
                    eig = (m_own[k] == 1);
                    edg = (m_own[k] == 2);
                    chk("i_gnt", k, 32'(i_gnt_w[k]), 32'(eig));
                    chk("d_gnt", k, 32'(d_gnt_w[k]), 32'(edg));
                    chk("mem_rd", k, 32'(mem_rd_w[k]), 32'(eig ? i_rd : (edg ? d_rd : 1'b0)));
                    chk("mem_wr", k, 32'(mem_wr_w[k]), 32'(eig ? i_wr : (edg ? d_wr : 1'b0)));
                    chk("mem_addr", k, 32'(mem_addr_w[k]), 32'(eig ? i_addr : (edg ? d_addr : 16'h0)));
                    chk("mem_wdata", k, 32'(mem_wdata_w[k]), 32'(eig ? i_wdata : (edg ? d_wdata : 16'h0)));
                    chk("i_stall", k, 32'(i_stall_w[k]), 32'(!eig || mem_stall));
                    chk("d_stall", k, 32'(d_stall_w[k]), 32'(!edg || mem_stall));
                    chk("rdata", k, 32'(rdata_w[k]), 32'(mem_rdata));
                    chk("hold_err", k, 32'(hold_err_w[k]), 32'(m_err[k]));
                end
            end
        end
    end

    // Advance one clock; return just after the negedge compare.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1; i_req = 1; d_req = 1; i_rd = 0; i_wr = 0; d_rd = 0; d_wr = 0;
        i_addr = '0; d_addr = '0; i_wdata = 16'hAAAA; d_wdata = 16'h5555;
        mem_busy = 4'b0; mem_stall = 0; mem_rdata = 16'hBEEF;

        // Reset with both requests high
        cyc(); cyc();
        chk("rst_i_gnt", 0, 32'(i_gnt_w[0]), 0);
        chk("rst_d_gnt", 0, 32'(d_gnt_w[0]), 0);
        chk("rst_i_stall", 0, 32'(i_stall_w[0]), 1);
        chk("rst_d_stall", 0, 32'(d_stall_w[0]), 1);
        chk("rst_mem_rd", 0, 32'(mem_rd_w[0]), 0);
        chk("rst_hold_err", 0, 32'(hold_err_w[0]), 0);

        // First tie after reset goes to D
        rst = 0; d_rd = 1; d_addr = 16'h1234;
        cyc();
        chk("tie_d_gnt", 0, 32'(d_gnt_w[0]), 1);
        chk("tie_i_gnt", 0, 32'(i_gnt_w[0]), 0);
        chk("tie_addr", 0, 32'(mem_addr_w[0]), 32'h1234);
        chk("tie_d_gnt", 1, 32'(d_gnt_w[1]), 1);

        // D holds while I waits: limit 4 reached after four owner cycles
        cyc(); cyc(); cyc();
        chk("hold_pre", 0, 32'(hold_err_w[0]), 0);
        cyc();
        chk("hold_hit", 0, 32'(hold_err_w[0]), 1);
        chk("hold_lim8", 1, 32'(hold_err_w[1]), 0);

        // D releases with no busy banks: IDLE, then I granted
        d_req = 0; d_rd = 0; i_rd = 1; i_addr = 16'h0040;
        cyc();
        chk("gap_i_gnt", 0, 32'(i_gnt_w[0]), 0);
        chk("gap_d_gnt", 0, 32'(d_gnt_w[0]), 0);
        cyc();
        chk("single_i_gnt", 0, 32'(i_gnt_w[0]), 1);
        chk("single_mem_rd", 0, 32'(mem_rd_w[0]), 1);
        chk("single_addr", 0, 32'(mem_addr_w[0]), 32'h0040);
        chk("single_i_stall", 0, 32'(i_stall_w[0]), 0);
        chk("single_d_stall", 0, 32'(d_stall_w[0]), 1);
        chk("sticky_err", 0, 32'(hold_err_w[0]), 1);
        mem_stall = 1; #1;
        chk("stall_pass", 0, 32'(i_stall_w[0]), 1);
        mem_stall = 0;

        // I releases while a bank is busy: two drain cycles, then D
        i_req = 0; i_wr = 1; mem_busy = 4'b0100; d_req = 1;
        cyc();
        chk("drain_i_gnt", 0, 32'(i_gnt_w[0]), 0);
        chk("drain_mem_wr", 0, 32'(mem_wr_w[0]), 0);
        cyc();
        chk("drain2_d_gnt", 0, 32'(d_gnt_w[0]), 0);
        mem_busy = 4'b0;
        cyc();
        chk("drain_idle", 0, 32'(d_gnt_w[0]), 0);
        cyc();
        chk("post_drain_d", 0, 32'(d_gnt_w[0]), 1);

        // Round-robin versus fixed priority on a fresh tie (last owner D)
        i_req = 1; d_req = 0; i_wr = 0;
        cyc();
        d_req = 1;
        cyc();
        chk("rr_i_gnt", 0, 32'(i_gnt_w[0]), 1);
        chk("fp_d_gnt", 1, 32'(d_gnt_w[1]), 1);
        chk("fp_i_gnt", 1, 32'(i_gnt_w[1]), 0);

        // Reset mid-transaction clears grant and error immediately
        rst = 1;
        cyc();
        chk("rst_mid_gnt", 0, 32'(i_gnt_w[0]), 0);
        chk("rst_mid_err", 0, 32'(hold_err_w[0]), 0);
        rst = 0;

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) i_req = ~i_req;
            if ($urandom_range(0, 7) == 0) d_req = ~d_req;
            i_rd      = 1'($urandom_range(0, 1));
            i_wr      = 1'($urandom_range(0, 1));
            d_rd      = 1'($urandom_range(0, 1));
            d_wr      = 1'($urandom_range(0, 1));
            i_addr    = 16'($urandom);
            d_addr    = 16'($urandom);
            i_wdata   = 16'($urandom);
            d_wdata   = 16'($urandom);
            mem_rdata = 16'($urandom);
            mem_busy  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
            mem_stall = ($urandom_range(0, 3) == 0);
            rst       = ($urandom_range(0, 299) == 0);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single four-banked main memory between the instruction-cache controller (I side) and the data-cache controller (D side).
- Each controller holds its request for a whole transaction: a 4-word write-back, a 4-word fill, or both back to back. The arbiter locks the grant to one owner until that request drops.
- Before handing the memory to the other side, it drains in-flight bank accesses (busy != 0).
- Sits between both cache controllers and the memory; routes address, data and control to memory and stall back to the requesters.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- PRIO_MODE, 0, 0 = round-robin on simultaneous requests, 1 = fixed D priority.
- MAX_HOLD, 64, cycles an owner may hold the grant while the other side waits before hold_err is raised.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_req  in  1  I side transaction request, held for whole transaction
- i_rd  in  1  I side memory read strobe
- i_wr  in  1  I side memory write strobe
- i_addr  in  ADDR_W  I side address
- i_wdata  in  DATA_W  I side write data
- d_req  in  1  D side transaction request
- d_rd  in  1  D side memory read strobe
- d_wr  in  1  D side memory write strobe
- d_addr  in  ADDR_W  D side address
- d_wdata  in  DATA_W  D side write data
- mem_busy  in  4  per-bank busy from memory
- mem_stall  in  1  memory stall
- mem_rdata  in  DATA_W  memory read data
- mem_rd  out  1  read to memory
- mem_wr  out  1  write to memory
- mem_addr  out  ADDR_W  address to memory
- mem_wdata  out  DATA_W  write data to memory
- i_gnt  out  1  I side owns memory
- d_gnt  out  1  D side owns memory
- i_stall  out  1  stall to I side
- d_stall  out  1  stall to D side
- rdata  out  DATA_W  mem_rdata broadcast to both sides
- hold_err  out  1  sticky hold-limit violation

Behaviour:
- Reset: rst sampled on clk.
  - State to IDLE; i_gnt = d_gnt = 0; hold_cnt = 0; hold_err = 0.
  - last_owner = I, so D wins the first tie.
  - mem_rd = mem_wr = 0; i_stall = d_stall = 1.
  - Reset mid-transaction aborts the grant immediately. No drain is performed.
- States: IDLE, OWN_I, OWN_D, DRAIN. i_gnt and d_gnt are registered decodes of OWN_I and OWN_D; at most one is ever high.
- IDLE:
  - Only d_req → OWN_D. Only i_req → OWN_I. Neither → stay.
  - Both, PRIO_MODE=0 → grant the side that is not last_owner.
  - Both, PRIO_MODE=1 → OWN_D.
  - Grant latency: request seen in IDLE at cycle N → gnt high at cycle N+1.
- OWN_x:
  - Memory outputs are muxed combinationally from side x. mem_rd = x_rd & gnt_x, mem_wr = x_wr & gnt_x.
  - last_owner is set to x on entry.
  - While x_req = 1, stay in OWN_x. The grant is never pre-empted.
  - x_req = 0 and mem_busy == 0 → IDLE.
  - x_req = 0 and mem_busy != 0 → DRAIN.
- DRAIN:
  - No grant; mem_rd = mem_wr = 0.
  - mem_busy == 0 → IDLE. A re-request by the previous owner during DRAIN is still arbitrated in IDLE.
- IDLE is never bypassed: there is a minimum one-cycle gap between successive grants, even to the same side.
- Stall: x_stall = ~x_gnt | mem_stall. A non-owner is always stalled; the owner sees mem_stall passed through.
- rdata = mem_rdata, unconditionally.
- When no grant is held, mem_addr and mem_wdata are 0.
- hold_cnt (8 bits, saturating):
  - Cleared on any cycle not in OWN_x.
  - Increments each OWN_x cycle while the other side's req = 1.
  - hold_cnt == MAX_HOLD → hold_err set. It stays set until rst.
- A requester strobing rd/wr without a grant has no effect on memory.

Test Plan:
- Reset:
  - Stimulus: rst=1 for 2 cycles with both reqs high.
  - Response: both gnts 0, both stalls 1, mem_rd/mem_wr 0, hold_err 0.
  - Stimulus: release rst.
  - Response: d_gnt=1 one cycle later (tie, last_owner=I).
- Single requester:
  - Stimulus: i_req=1 at cycle 5 with i_rd=1, i_addr=0x0040.
  - Response: i_gnt=1 at cycle 6; mem_rd=1, mem_addr=0x0040; i_stall=0 while mem_stall=0; d_stall=1.
- Round-robin (PRIO_MODE=0):
  - Stimulus: both reqs held; D finishes at cycle 20 with mem_busy=0.
  - Response: IDLE at 21, i_gnt=1 at 22.
  - Stimulus: I finishes while D still requesting.
  - Response: d_gnt next.
- Drain:
  - Stimulus: d_req drops at cycle 30 while mem_busy=4'b0100 until cycle 32.
  - Response: DRAIN at cycles 31–32; no mem_wr; pending i_req granted at cycle 34.
- Fixed priority (PRIO_MODE=1):
  - Stimulus: both reqs after every release.
  - Response: D is always granted; I is granted only when d_req=0.
- Hold error (MAX_HOLD=4):
  - Stimulus: D holds the grant while i_req=1.
  - Response: hold_err rises on the cycle hold_cnt reaches 4; stays 1 after d_req drops; cleared only by rst.
